// File: rtl/player_hand_if.sv
// Player hand bus: draw requests, deck strobes, play/read-out and status.
// The hand itself sits on the slave side; the game/deck side uses master.
interface player_hand_if;
    logic [2:0] i_req;
    logic       i_deck_done;
    logic       i_deck_drawn;
    logic [5:0] i_deck_card;
    logic [2:0] o_draw;
    logic       i_play;
    logic [5:0] i_idx;
    logic       i_clear;
    logic [5:0] o_sel_card;
    logic       o_played;
    logic [5:0] o_played_card;
    logic [5:0] o_count;
    logic       o_busy;
    logic       o_err;
    logic       o_overflow;

    modport slave (
        input  i_req, i_deck_done, i_deck_drawn, i_deck_card,
        input  i_play, i_idx, i_clear,
        output o_draw, o_sel_card, o_played, o_played_card,
        output o_count, o_busy, o_err, o_overflow
    );

    modport master (
        output i_req, i_deck_done, i_deck_drawn, i_deck_card,
        output i_play, i_idx, i_clear,
        input  o_draw, o_sel_card, o_played, o_played_card,
        input  o_count, o_busy, o_err, o_overflow
    );
endinterface

// File: rtl/player_hand.sv
// Card hand: collects cards drawn from the deck, removes played cards
// by compacting the slots, and exposes a combinational slot read-out.
module player_hand #(
    parameter int MAX_CARDS = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    player_hand_if.slave  hand
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_COLLECT,
        S_REMOVE
    } state_t;

    state_t                    state;
    logic [MAX_CARDS-1:0][5:0] slots;
    logic [MAX_CARDS-1:0][5:0] up;
    logic [5:0]                count;
    logic [5:0]                idx_q;
    logic [2:0]                remaining;
    logic [2:0]                draw;
    logic [5:0]                played_card;
    logic [5:0]                sel;
    logic                      played;
    logic                      err;
    logic                      overflow;
    logic                      busy;
    logic                      req_ok;
    logic [2:0]                req_n;
    logic                      full;

    always_comb begin
        req_ok = 1'b1;
        req_n  = 3'd0;
        case (hand.i_req)
            3'b001:  req_n = 3'd1;
            3'b010:  req_n = 3'd2;
            3'b100:  req_n = 3'd4;
            default: req_ok = 1'b0;
        endcase
    end

    // up[i] is the card one slot above i; the top slot sees an empty card
    assign up   = {6'd0, slots[MAX_CARDS-1:1]};
    assign full = (count == 6'(MAX_CARDS));

    always_comb begin
        sel = 6'd0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            if (6'(i) == hand.i_idx && 6'(i) < count) sel = slots[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            slots       <= '0;
            count       <= 6'd0;
            idx_q       <= 6'd0;
            remaining   <= 3'd0;
            draw        <= 3'd0;
            played_card <= 6'd0;
            played      <= 1'b0;
            err         <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            played <= 1'b0;
            err    <= 1'b0;
            if (hand.i_clear) begin
                state     <= S_IDLE;
                slots     <= '0;
                count     <= 6'd0;
                remaining <= 3'd0;
                overflow  <= 1'b0;
                draw      <= 3'd0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (req_ok && hand.i_deck_done) begin
                            remaining <= req_n;
                            draw      <= hand.i_req;
                            busy      <= 1'b1;
                            state     <= S_REQ;
                        end else if (hand.i_play) begin
                            if (hand.i_idx < count) begin
                                played_card <= sel;
                                idx_q       <= hand.i_idx;
                                state       <= S_REMOVE;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_REQ, S_COLLECT: begin
                        if (state == S_REQ) state <= S_COLLECT;
                        if (hand.i_deck_drawn) begin
                            if (full) begin
                                overflow <= 1'b1;
                            end else begin
                                for (int i = 0; i < MAX_CARDS; i++) begin
                                    if (6'(i) == count) slots[i] <= hand.i_deck_card;
                                end
                                count <= count + 6'd1;
                            end
                            remaining <= remaining - 3'd1;
                            if (remaining == 3'd1) begin
                                state <= S_IDLE;
                                draw  <= 3'd0;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    S_REMOVE: begin
                        // slots at or above count are already zero
                        for (int i = 0; i < MAX_CARDS; i++) begin
                            if (6'(i) >= idx_q && 6'(i) < count) slots[i] <= up[i];
                        end
                        count  <= count - 6'd1;
                        played <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign hand.o_draw        = draw;
    assign hand.o_sel_card    = sel;
    assign hand.o_played      = played;
    assign hand.o_played_card = played_card;
    assign hand.o_count       = count;
    assign hand.o_busy        = busy;
    assign hand.o_err         = err;
    assign hand.o_overflow    = overflow;
endmodule

// File: tb/tb_player_hand.sv
// Bench for player_hand: directed scenarios plus random draw/play/clear
// traffic checked against a queue model of the hand.
module tb_player_hand;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   q[$];
    bit   ovf = 1'b0;
    localparam int MAXA = 32;

    player_hand_if a();
    player_hand_if b();

    player_hand u_a (.i_clk(clk), .i_rst_n(rst_n), .hand(a.slave));
    player_hand #(.MAX_CARDS(2)) u_b (.i_clk(clk), .i_rst_n(rst_n), .hand(b.slave));

    always #100 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a.i_req = 0; a.i_deck_done = 1; a.i_deck_drawn = 0; a.i_deck_card = 0;
        a.i_play = 0; a.i_idx = 0; a.i_clear = 0;
        b.i_req = 0; b.i_deck_done = 1; b.i_deck_drawn = 0; b.i_deck_card = 0;
        b.i_play = 0; b.i_idx = 0; b.i_clear = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        repeat (2) tick();
        n_tests++;
        if (a.o_count !== 0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", a.o_count); end
        n_tests++;
        if (a.o_draw !== 0 || a.o_busy !== 0) begin
            n_fail++; $display("FAIL rst_draw got %b/%b exp 000/0", a.o_draw, a.o_busy);
        end
        n_tests++;
        if (a.o_played !== 0 || a.o_err !== 0 || a.o_overflow !== 0 || a.o_played_card !== 0) begin
            n_fail++; $display("FAIL rst_flags got %b%b%b %h exp 000 00",
                a.o_played, a.o_err, a.o_overflow, a.o_played_card);
        end
        n_tests++;
        if (a.o_sel_card !== 0) begin n_fail++; $display("FAIL rst_sel got %h exp 00", a.o_sel_card); end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (a.o_busy !== 0 || a.o_count !== 0) begin
            n_fail++; $display("FAIL rst_release got busy %b count %0d exp 0 0", a.o_busy, a.o_count);
        end
    endtask

    task automatic test_draw_four();
        logic [5:0] c[4] = '{6'h01, 6'h12, 6'h2D, 6'h3E};
        a.i_req = 3'b100;
        tick();
        a.i_req = 0;
        n_tests++;
        if (a.o_draw !== 3'b100 || a.o_busy !== 1) begin
            n_fail++; $display("FAIL draw4_start got %b/%b exp 100/1", a.o_draw, a.o_busy);
        end
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            n_tests++;
            if (a.o_draw !== 3'b100) begin
                n_fail++; $display("FAIL draw4_hold%0d got %b exp 100", k, a.o_draw);
            end
            a.i_deck_drawn = 1; a.i_deck_card = c[k];
            tick();
            a.i_deck_drawn = 0;
            q.push_back(int'(c[k]));
            n_tests++;
            if (a.o_draw !== ((k == 3) ? 3'b000 : 3'b100) || a.o_busy !== (k != 3)) begin
                n_fail++; $display("FAIL draw4_strobe%0d got %b/%b", k, a.o_draw, a.o_busy);
            end
        end
        n_tests++;
        if (a.o_count !== 4) begin n_fail++; $display("FAIL draw4_count got %0d exp 4", a.o_count); end
        for (int k = 0; k < 5; k++) begin
            a.i_idx = 6'(k); #1;
            n_tests++;
            if (a.o_sel_card !== ((k < 4) ? c[k] : 6'h00)) begin
                n_fail++; $display("FAIL draw4_slot%0d got %h", k, a.o_sel_card);
            end
        end
        a.i_idx = 0;
    endtask

    task automatic test_play();
        a.i_play = 1; a.i_idx = 1;
        tick();
        a.i_play = 0;
        n_tests++;
        if (a.o_played !== 0) begin n_fail++; $display("FAIL play_early got %b exp 0", a.o_played); end
        tick();
        q.delete(1);
        n_tests++;
        if (a.o_played !== 1 || a.o_played_card !== 6'h12) begin
            n_fail++; $display("FAIL play_strobe got %b %h exp 1 12", a.o_played, a.o_played_card);
        end
        n_tests++;
        if (a.o_count !== 3) begin n_fail++; $display("FAIL play_count got %0d exp 3", a.o_count); end
        for (int k = 0; k < 4; k++) begin
            a.i_idx = 6'(k); #1;
            n_tests++;
            if (a.o_sel_card !== ((k < 3) ? 6'(q[k]) : 6'h00)) begin
                n_fail++; $display("FAIL play_slot%0d got %h", k, a.o_sel_card);
            end
        end
        tick();
        n_tests++;
        if (a.o_played !== 0 || a.o_played_card !== 6'h12) begin
            n_fail++; $display("FAIL play_pulse got %b %h exp 0 12", a.o_played, a.o_played_card);
        end
    endtask

    task automatic test_err_empty();
        a.i_clear = 1;
        tick();
        a.i_clear = 0;
        q.delete(); ovf = 0;
        n_tests++;
        if (a.o_count !== 0) begin n_fail++; $display("FAIL clr_count got %0d exp 0", a.o_count); end
        a.i_play = 1; a.i_idx = 0;
        tick();
        a.i_play = 0;
        n_tests++;
        if (a.o_err !== 1 || a.o_count !== 0 || a.o_played !== 0) begin
            n_fail++; $display("FAIL err_pulse got %b %0d %b exp 1 0 0", a.o_err, a.o_count, a.o_played);
        end
        tick();
        n_tests++;
        if (a.o_err !== 0 || a.o_played !== 0 || a.o_busy !== 0) begin
            n_fail++; $display("FAIL err_clear got %b %b %b exp 0 0 0", a.o_err, a.o_played, a.o_busy);
        end
    endtask

    task automatic test_overflow();
        logic [5:0] c[3] = '{6'h07, 6'h05, 6'h06};
        b.i_clear = 1; tick(); b.i_clear = 0;
        b.i_req = 3'b001; tick(); b.i_req = 0;
        b.i_deck_drawn = 1; b.i_deck_card = c[0]; tick(); b.i_deck_drawn = 0;
        b.i_req = 3'b010; tick(); b.i_req = 0;
        for (int k = 1; k < 3; k++) begin
            b.i_deck_drawn = 1; b.i_deck_card = c[k]; tick(); b.i_deck_drawn = 0;
        end
        n_tests++;
        if (b.o_count !== 2 || b.o_overflow !== 1 || b.o_busy !== 0 || b.o_draw !== 0) begin
            n_fail++; $display("FAIL ovf_state got %0d %b %b %b exp 2 1 0 000",
                b.o_count, b.o_overflow, b.o_busy, b.o_draw);
        end
        for (int k = 0; k < 2; k++) begin
            b.i_idx = 6'(k); #1;
            n_tests++;
            if (b.o_sel_card !== c[k]) begin
                n_fail++; $display("FAIL ovf_slot%0d got %h exp %h", k, b.o_sel_card, c[k]);
            end
        end
        b.i_idx = 0;
    endtask

    task automatic test_simultaneous();
        bit saw_err = 0, saw_play = 0;
        b.i_req = 3'b001; b.i_play = 1; b.i_idx = 0;
        tick();
        b.i_req = 0; b.i_play = 0;
        saw_err |= b.o_err; saw_play |= b.o_played;
        n_tests++;
        if (b.o_busy !== 1 || b.o_draw !== 3'b001) begin
            n_fail++; $display("FAIL sim_draw got %b %b exp 1 001", b.o_busy, b.o_draw);
        end
        b.i_deck_drawn = 1; b.i_deck_card = 6'h09; tick(); b.i_deck_drawn = 0;
        saw_err |= b.o_err; saw_play |= b.o_played;
        tick();
        saw_err |= b.o_err; saw_play |= b.o_played;
        n_tests++;
        if (saw_err || saw_play || b.o_count !== 2 || b.o_busy !== 0) begin
            n_fail++; $display("FAIL sim_result got err %b play %b count %0d busy %b exp 0 0 2 0",
                saw_err, saw_play, b.o_count, b.o_busy);
        end
        b.i_clear = 1; tick(); b.i_clear = 0;
        n_tests++;
        if (b.o_count !== 0 || b.o_overflow !== 0) begin
            n_fail++; $display("FAIL sim_clear got %0d %b exp 0 0", b.o_count, b.o_overflow);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            int op = $urandom_range(0, 9);
            if (op <= 5) begin
                int n = 1 << $urandom_range(0, 2);
                a.i_req = 3'(n);
                if ($urandom_range(0, 3) == 0) begin
                    a.i_deck_done = 0;
                    tick();
                    n_tests++;
                    if (a.o_busy !== 0) begin n_fail++; $display("FAIL rnd_notdone got busy %b exp 0", a.o_busy); end
                    a.i_deck_done = 1;
                end
                tick();
                a.i_req = 0;
                for (int k = 0; k < n; k++) begin
                    logic [5:0] card = 6'($urandom);
                    repeat ($urandom_range(0, 1)) tick();
                    a.i_deck_drawn = 1; a.i_deck_card = card; tick(); a.i_deck_drawn = 0;
                    if (q.size() < MAXA) q.push_back(int'(card)); else ovf = 1;
                end
                n_tests++;
                if (a.o_busy !== 0 || a.o_draw !== 0) begin
                    n_fail++; $display("FAIL rnd_drawend got %b %b exp 0 000", a.o_busy, a.o_draw);
                end
            end else if (op <= 7) begin
                int idx = $urandom_range(0, q.size() + 1);
                bit legal = idx < q.size();
                a.i_play = 1; a.i_idx = 6'(idx);
                tick();
                a.i_play = 0;
                n_tests++;
                if (a.o_err !== !legal) begin
                    n_fail++; $display("FAIL rnd_err idx %0d got %b exp %b", idx, a.o_err, !legal);
                end
                if (legal) begin
                    tick();
                    n_tests++;
                    if (a.o_played !== 1 || a.o_played_card !== 6'(q[idx])) begin
                        n_fail++; $display("FAIL rnd_play got %b %h exp 1 %h", a.o_played, a.o_played_card, 6'(q[idx]));
                    end
                    q.delete(idx);
                end
            end else if (op == 8) begin
                a.i_deck_drawn = 1; a.i_deck_card = 6'($urandom); tick(); a.i_deck_drawn = 0;
            end else begin
                a.i_clear = 1; tick(); a.i_clear = 0;
                q.delete(); ovf = 0;
            end
            n_tests++;
            if (a.o_count !== 6'(q.size()) || a.o_overflow !== ovf) begin
                n_fail++; $display("FAIL rnd_count it %0d got %0d %b exp %0d %b",
                    it, a.o_count, a.o_overflow, q.size(), ovf);
            end
            for (int k = 0; k < MAXA; k++) begin
                a.i_idx = 6'(k); #1;
                n_tests++;
                if (a.o_sel_card !== ((k < q.size()) ? 6'(q[k]) : 6'h00)) begin
                    n_fail++; $display("FAIL rnd_slot it %0d slot %0d got %h", it, k, a.o_sel_card);
                end
            end
            a.i_idx = 0;
        end
    endtask

    task automatic test_reset_mid_draw();
        a.i_clear = 1; tick(); a.i_clear = 0;
        q.delete(); ovf = 0;
        a.i_req = 3'b100; tick(); a.i_req = 0;
        for (int k = 0; k < 2; k++) begin
            a.i_deck_drawn = 1; a.i_deck_card = 6'(k + 3); tick(); a.i_deck_drawn = 0;
        end
        n_tests++;
        if (a.o_busy !== 1 || a.o_count !== 2) begin
            n_fail++; $display("FAIL mid_pre got %b %0d exp 1 2", a.o_busy, a.o_count);
        end
        rst_n = 0;
        #1;
        n_tests++;
        if (a.o_draw !== 0 || a.o_count !== 0 || a.o_busy !== 0) begin
            n_fail++; $display("FAIL mid_async got %b %0d %b exp 000 0 0", a.o_draw, a.o_count, a.o_busy);
        end
        tick();
        rst_n = 1;
        tick();
        n_tests++;
        if (a.o_draw !== 0 || a.o_busy !== 0 || a.o_count !== 0) begin
            n_fail++; $display("FAIL mid_release got %b %b %0d exp 000 0 0", a.o_draw, a.o_busy, a.o_count);
        end
    endtask

    initial begin
        test_reset();
        test_draw_four();
        test_play();
        test_err_empty();
        test_overflow();
        test_simultaneous();
        test_random();
        test_reset_mid_draw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
